// File: rtl/conv_pkg.sv
// Shared configuration, state encoding and width helper for the convolution
// loop-nest controller.
package conv_pkg;

  typedef struct packed {
    int unsigned FEATURE_MAP_WIDTH;
    int unsigned FEATURE_MAP_HEIGHT;
    int unsigned INPUT_NB_CHANNELS;
    int unsigned OUTPUT_NB_CHANNELS;
    int unsigned KERNEL_SIZE;
    int unsigned DATA_WIDTH;
  } config_t;

  localparam config_t DEFAULT_CFG = '{
    FEATURE_MAP_WIDTH:  4,
    FEATURE_MAP_HEIGHT: 4,
    INPUT_NB_CHANNELS:  2,
    OUTPUT_NB_CHANNELS: 2,
    KERNEL_SIZE:        3,
    DATA_WIDTH:         8
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } ctrl_state_t;

  // Counter width for a range of n values; a single-value range still gets one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_loop_ctrl_wrap_counter.sv
// Modulo-MAX counter with a terminal flag; chained through (last && en) to
// build the loop nest.
module wrap_counter
  import conv_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [cw(MAX)-1:0] value,
  output logic             last
);

  localparam int VW = cw(MAX);
  localparam logic [VW-1:0] TOP = VW'(MAX - 1);

  logic [VW-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (en) begin
      value_d = last ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;
  assign last  = (value_q == TOP);

endmodule

// File: rtl/conv_loop_ctrl.sv
// Loop-nest controller: walks output pixels and their kernel taps, pairs the
// activation/weight streams into MAC enables and flags finished pixels.
module conv_loop_ctrl
  import conv_pkg::*;
#(
  parameter config_t cfg = conv_pkg::DEFAULT_CFG
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  output logic                                        running,
  output logic                                        done,
  input  logic                                        a_valid,
  output logic                                        a_ready,
  input  logic                                        b_valid,
  output logic                                        b_ready,
  output logic [cw(int'(cfg.FEATURE_MAP_WIDTH))-1:0]  act_x,
  output logic [cw(int'(cfg.FEATURE_MAP_HEIGHT))-1:0] act_y,
  output logic [cw(int'(cfg.INPUT_NB_CHANNELS))-1:0]  tap_ci,
  output logic [cw(int'(cfg.KERNEL_SIZE))-1:0]        tap_kx,
  output logic [cw(int'(cfg.KERNEL_SIZE))-1:0]        tap_ky,
  output logic                                        mac_en,
  output logic                                        mac_clear,
  output logic                                        out_valid,
  output logic [cw(int'(cfg.FEATURE_MAP_WIDTH))-1:0]  out_x,
  output logic [cw(int'(cfg.FEATURE_MAP_HEIGHT))-1:0] out_y,
  output logic [cw(int'(cfg.OUTPUT_NB_CHANNELS))-1:0] out_ch,
  output logic [1:0]                                  dbg_state
);

  localparam int W     = int'(cfg.FEATURE_MAP_WIDTH);
  localparam int H     = int'(cfg.FEATURE_MAP_HEIGHT);
  localparam int CI    = int'(cfg.INPUT_NB_CHANNELS);
  localparam int CO    = int'(cfg.OUTPUT_NB_CHANNELS);
  localparam int K     = int'(cfg.KERNEL_SIZE);
  localparam int XW    = cw(W);
  localparam int YW    = cw(H);
  localparam int MAXWH = (W > H) ? W : H;
  localparam int IW    = $clog2(MAXWH) + 2;

  localparam logic signed [IW-1:0] ZERO = '0;
  localparam logic signed [IW-1:0] HALF = IW'(K / 2);
  localparam logic signed [IW-1:0] X_HI = IW'(W - 1);
  localparam logic signed [IW-1:0] Y_HI = IW'(H - 1);

  ctrl_state_t state_q, state_d;
  logic        done_q, done_d;

  logic kx_last, ky_last, ci_last, ox_last, oy_last, ch_last;
  logic in_fetch, in_write, cnt_clr;
  logic pad, fire, inner_adv, inner_last, last_pixel;
  logic signed [IW-1:0] ix, iy;

  assign in_fetch = (state_q == FETCH);
  assign in_write = (state_q == WRITE);
  assign cnt_clr  = (state_q == IDLE);

  // Inner loop: kx fastest, then ky, then ci.
  wrap_counter #(.MAX(K))  u_kx (.clk, .rst, .clr(cnt_clr), .en(inner_adv),
                                 .value(tap_kx), .last(kx_last));
  wrap_counter #(.MAX(K))  u_ky (.clk, .rst, .clr(cnt_clr), .en(inner_adv && kx_last),
                                 .value(tap_ky), .last(ky_last));
  wrap_counter #(.MAX(CI)) u_ci (.clk, .rst, .clr(cnt_clr), .en(inner_adv && kx_last && ky_last),
                                 .value(tap_ci), .last(ci_last));

  // Outer loop advances once per WRITE; everything wraps to zero after the last pixel.
  wrap_counter #(.MAX(W))  u_ox (.clk, .rst, .clr(cnt_clr), .en(in_write),
                                 .value(out_x), .last(ox_last));
  wrap_counter #(.MAX(H))  u_oy (.clk, .rst, .clr(cnt_clr), .en(in_write && ox_last),
                                 .value(out_y), .last(oy_last));
  wrap_counter #(.MAX(CO)) u_ch (.clk, .rst, .clr(cnt_clr), .en(in_write && ox_last && oy_last),
                                 .value(out_ch), .last(ch_last));

  assign ix = $signed(IW'(out_x)) + $signed(IW'(tap_kx)) - HALF;
  assign iy = $signed(IW'(out_y)) + $signed(IW'(tap_ky)) - HALF;
  assign pad = (ix < ZERO) || (ix > X_HI) || (iy < ZERO) || (iy > Y_HI);

  // Cross-coupled readies make the two streams transfer together or not at all.
  assign fire       = a_valid && b_valid;
  assign a_ready    = in_fetch && !pad && b_valid;
  assign b_ready    = in_fetch && !pad && a_valid;
  assign mac_en     = in_fetch && !pad && fire;
  assign inner_adv  = in_fetch && (pad || fire);
  assign inner_last = kx_last && ky_last && ci_last;
  assign last_pixel = ox_last && oy_last && ch_last;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (inner_adv && inner_last) state_d = WRITE;
      WRITE: begin
        state_d = last_pixel ? IDLE : FETCH;
        done_d  = last_pixel;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign running   = in_fetch || in_write;
  assign done      = done_q;
  assign out_valid = in_write;
  assign mac_clear = in_write;
  assign act_x     = in_fetch ? ix[XW-1:0] : '0;
  assign act_y     = in_fetch ? iy[YW-1:0] : '0;
  assign dbg_state = state_q;

endmodule
